if_fetch_unit: RTL and testbench

//  Consumer side of the program counter register. Takes the current PC, computes and returns the next PC, and issues in-order instruction-memory reads.

---
 rtl/if_fetch_unit_pkg.sv | 21 ++
 rtl/if_sync_fifo.sv | 83 ++++++++
 rtl/if_fetch_unit.sv | 138 +++++++++++++
 tb/tb_if_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, PC constants and the instruction-buffer entry layout for the fetch unit.
package if_fetch_unit_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] RESET_PC = '0;

   // One buffered instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] data;
   } inst_entry_t;

   // Sequential next PC; wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/if_sync_fifo.sv
// Small synchronous FIFO with occupancy count and a single-cycle clear.
// Clear takes priority over push and pop in the same cycle.
module if_sync_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 32,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // Pointer wrap that also works for a non-power-of-two depth.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Next pointer and occupancy values.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents are don't-care until counted valid.
   always_ff @(posedge clk) begin
      if (do_push && !clear_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues in-order imem reads from the current PC, tags each with
// its PC, buffers returned words for decode and discards wrong-path responses
// left in flight by a redirect.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned MAX_OUT    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_i,
   output logic [ADDR_W-1:0] pc_next_o,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_target_i,
   output logic              imem_req_valid_o,
   input  logic              imem_req_ready_i,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_rsp_valid_i,
   input  logic [DATA_W-1:0] imem_rsp_data_i,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o
);

   localparam int unsigned OUT_W  = $clog2(MAX_OUT + 1);
   localparam int unsigned ICNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W  = ICNT_W + 1;

   logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
   logic [OUT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic [OUT_W-1:0]  live;
   logic [ICNT_W-1:0] inst_count;
   logic              issue, rsp_acc;
   logic              inst_push, inst_pop, inst_empty, inst_full;
   logic [ADDR_W-1:0] tag_pc;
   logic              tag_full, tag_empty;
   logic [OUT_W-1:0]  tag_count;
   inst_entry_t       inst_wdata, inst_rdata;
   logic              unused_fifo_status;

   // Requests still in flight whose words will be kept.
   assign live = out_cnt_q - drop_cnt_q;

   // Credit check reserves a buffer slot for every live request; held off during reset.
   assign imem_req_valid_o = !reset && !redirect_i && (out_cnt_q < OUT_W'(MAX_OUT)) &&
                             ((SUM_W'(inst_count) + SUM_W'(live)) < SUM_W'(FIFO_DEPTH));
   assign issue       = imem_req_valid_o && imem_req_ready_i;
   assign imem_addr_o = pc_i;

   // A response with nothing outstanding is stray (e.g. after reset) and ignored.
   assign rsp_acc = imem_rsp_valid_i && (out_cnt_q != '0);

   // Words are kept only when no drop credit remains and no redirect is squashing them.
   assign inst_push  = rsp_acc && (drop_cnt_q == '0) && !redirect_i;
   assign inst_pop   = inst_valid_o && inst_ready_i;
   assign inst_wdata = '{pc: tag_pc, data: imem_rsp_data_i};

   assign inst_valid_o = !inst_empty;
   assign inst_o       = inst_rdata.data;
   assign inst_pc_o    = inst_rdata.pc;

   assign unused_fifo_status = ^{tag_full, tag_empty, tag_count, inst_full};

   // Next PC: redirect wins, otherwise advance only when a request is accepted.
   always_comb begin
      pc_next_o = pc_i;
      if (redirect_i) begin
         pc_next_o = redirect_target_i;
      end else if (issue) begin
         pc_next_o = pc_incr(pc_i);
      end
   end

   // Outstanding and drop counters.
   always_comb begin
      out_cnt_d  = out_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (issue && !rsp_acc) begin
         out_cnt_d = out_cnt_q + OUT_W'(1);
      end else if (!issue && rsp_acc) begin
         out_cnt_d = out_cnt_q - OUT_W'(1);
      end
      if (redirect_i) begin
         // Everything still outstanding after this cycle is wrong-path.
         drop_cnt_d = out_cnt_q - OUT_W'(rsp_acc);
      end else if (rsp_acc && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - OUT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // PCs of outstanding requests, popped in response order.
   if_sync_fifo #(
      .DEPTH (MAX_OUT),
      .WIDTH (ADDR_W)
   ) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (issue),
      .wdata_i (pc_i),
      .pop_i   (rsp_acc),
      .clear_i (1'b0),
      .rdata_o (tag_pc),
      .full_o  (tag_full),
      .empty_o (tag_empty),
      .count_o (tag_count)
   );

   // Returned instructions waiting for decode; flushed on redirect.
   if_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(inst_entry_t))
   ) u_inst_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (inst_push),
      .wdata_i (inst_wdata),
      .pop_i   (inst_pop),
      .clear_i (redirect_i),
      .rdata_o (inst_rdata),
      .full_o  (inst_full),
      .empty_o (inst_empty),
      .count_o (inst_count)
   );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a per-cycle vector table for streaming and
// backpressure, then hand-written redirect, stall and mid-burst reset sequences.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_i;
   logic [31:0] pc_next_o;
   logic        redirect_i;
   logic [31:0] redirect_target_i;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;

   int n_vec = 0;
   int n_bad = 0;
   logic mem_auto = 1'b0;

   typedef struct {
      logic        inst_ready;
      logic [31:0] pc_next;
      logic        req_valid;
      logic        inst_valid;
      logic [31:0] inst_pc;
   } vec_t;

   vec_t vecs[$];

   if_fetch_unit #(
      .FIFO_DEPTH (2),
      .MAX_OUT    (2)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .pc_i              (pc_i),
      .pc_next_o         (pc_next_o),
      .redirect_i        (redirect_i),
      .redirect_target_i (redirect_target_i),
      .imem_req_valid_o  (imem_req_valid_o),
      .imem_req_ready_i  (imem_req_ready_i),
      .imem_addr_o       (imem_addr_o),
      .imem_rsp_valid_i  (imem_rsp_valid_i),
      .imem_rsp_data_i   (imem_rsp_data_i),
      .inst_valid_o      (inst_valid_o),
      .inst_ready_i      (inst_ready_i),
      .inst_o            (inst_o),
      .inst_pc_o         (inst_pc_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Called just after inputs settle; advances one clock, models the PC register
   // and, in auto mode, a memory that answers exactly one cycle after acceptance.
   task automatic tick();
      logic        iss;
      logic [31:0] a, nxt;
      iss = imem_req_valid_o && imem_req_ready_i;
      a   = imem_addr_o;
      nxt = pc_next_o;
      @(posedge clk);
      #1;
      pc_i = nxt;
      if (mem_auto) begin
         imem_rsp_valid_i = iss;
         imem_rsp_data_i  = iss ? mem_word(a) : 32'h0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      mem_auto         = 1'b0;
      redirect_i       = 1'b0;
      imem_rsp_valid_i = 1'b0;
      #1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset             = 1'b1;
      pc_i              = 32'h0;
      redirect_i        = 1'b0;
      redirect_target_i = 32'h0;
      imem_req_ready_i  = 1'b1;
      imem_rsp_valid_i  = 1'b0;
      imem_rsp_data_i   = 32'h0;
      inst_ready_i      = 1'b1;

      // Streaming from PC 0 with a one-cycle memory, then 10 cycles of decode stall.
      vecs.push_back('{1'b1, 32'd4,  1'b1, 1'b0, 32'd0});
      vecs.push_back('{1'b1, 32'd8,  1'b1, 1'b0, 32'd0});
      vecs.push_back('{1'b1, 32'd8,  1'b0, 1'b1, 32'd0});
      vecs.push_back('{1'b1, 32'd12, 1'b1, 1'b1, 32'd4});
      vecs.push_back('{1'b1, 32'd16, 1'b1, 1'b0, 32'd0});
      vecs.push_back('{1'b1, 32'd16, 1'b0, 1'b1, 32'd8});
      vecs.push_back('{1'b1, 32'd20, 1'b1, 1'b1, 32'd12});
      vecs.push_back('{1'b0, 32'd24, 1'b1, 1'b0, 32'd0});
      for (int i = 0; i < 9; i++) begin
         vecs.push_back('{1'b0, 32'd24, 1'b0, 1'b1, 32'd16});
      end
      vecs.push_back('{1'b1, 32'd24, 1'b0, 1'b1, 32'd16});
      vecs.push_back('{1'b1, 32'd28, 1'b1, 1'b1, 32'd20});
      vecs.push_back('{1'b1, 32'd32, 1'b1, 1'b0, 32'd0});

      @(negedge clk);
      #1;
      check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
      check("rst_inst_valid", 32'(inst_valid_o), 32'd0);
      check("rst_pc_next", pc_next_o, pc_i);
      @(negedge clk);
      reset    = 1'b0;
      mem_auto = 1'b1;

      foreach (vecs[i]) begin
         inst_ready_i = vecs[i].inst_ready;
         #1;
         check($sformatf("v%0d_pc_next", i), pc_next_o, vecs[i].pc_next);
         check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid_o), 32'(vecs[i].req_valid));
         check($sformatf("v%0d_addr", i), imem_addr_o, pc_i);
         check($sformatf("v%0d_inst_valid", i), 32'(inst_valid_o), 32'(vecs[i].inst_valid));
         if (vecs[i].inst_valid) begin
            check($sformatf("v%0d_inst_pc", i), inst_pc_o, vecs[i].inst_pc);
            check($sformatf("v%0d_inst", i), inst_o, mem_word(vecs[i].inst_pc));
         end
         tick();
      end

      // Reset mid-burst while a response is on the bus, then a stray response pulse.
      reset    = 1'b1;
      mem_auto = 1'b0;
      #1;
      check("mrst_req_valid", 32'(imem_req_valid_o), 32'd0);
      check("mrst_inst_valid", 32'(inst_valid_o), 32'd0);
      check("mrst_pc_next", pc_next_o, pc_i);
      tick();
      reset            = 1'b0;
      pc_i             = 32'h0;
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'hBAD0_BAD0;
      #1;
      check("stray_inst_valid0", 32'(inst_valid_o), 32'd0);
      check("stray_pc_next", pc_next_o, 32'h0);
      tick();
      imem_rsp_valid_i = 1'b0;
      #1;
      check("stray_inst_valid1", 32'(inst_valid_o), 32'd0);
      check("stray_req_valid", 32'(imem_req_valid_o), 32'd1);
      tick();

      // Redirect with two requests in flight.
      do_reset();
      pc_i             = 32'h40;
      imem_req_ready_i = 1'b1;
      inst_ready_i     = 1'b1;
      #1;
      check("rd_req0", 32'(imem_req_valid_o), 32'd1);
      check("rd_next0", pc_next_o, 32'h44);
      tick();
      #1;
      check("rd_next1", pc_next_o, 32'h48);
      tick();
      #1;
      check("rd_out_full", 32'(imem_req_valid_o), 32'd0);
      redirect_i        = 1'b1;
      redirect_target_i = 32'h100;
      #1;
      check("rd_target", pc_next_o, 32'h100);
      tick();
      redirect_i       = 1'b0;
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_word(32'h40);
      #1;
      check("rd_pc_after", pc_i, 32'h100);
      check("rd_still_full", 32'(imem_req_valid_o), 32'd0);
      tick();
      imem_rsp_data_i = mem_word(32'h44);
      #1;
      check("rd_drop1_iv", 32'(inst_valid_o), 32'd0);
      check("rd_next2", pc_next_o, 32'h104);
      tick();
      imem_rsp_data_i = mem_word(32'h100);
      #1;
      check("rd_drop2_iv", 32'(inst_valid_o), 32'd0);
      check("rd_next3", pc_next_o, 32'h108);
      tick();
      imem_rsp_valid_i = 1'b0;
      #1;
      check("rd_first_iv", 32'(inst_valid_o), 32'd1);
      check("rd_first_pc", inst_pc_o, 32'h100);
      check("rd_first_inst", inst_o, mem_word(32'h100));
      tick();

      // Redirect coinciding with a response, then request-ready stalls.
      do_reset();
      pc_i             = 32'h200;
      imem_req_ready_i = 1'b1;
      #1;
      check("rr_req0", 32'(imem_req_valid_o), 32'd1);
      tick();
      #1;
      check("rr_req1", 32'(imem_req_valid_o), 32'd1);
      tick();
      redirect_i        = 1'b1;
      redirect_target_i = 32'h300;
      imem_rsp_valid_i  = 1'b1;
      imem_rsp_data_i   = mem_word(32'h200);
      #1;
      check("rr_target", pc_next_o, 32'h300);
      check("rr_req_blocked", 32'(imem_req_valid_o), 32'd0);
      tick();
      redirect_i       = 1'b0;
      imem_rsp_valid_i = 1'b0;
      imem_req_ready_i = 1'b0;
      #1;
      check("rr_flushed_iv", 32'(inst_valid_o), 32'd0);
      check("rr_req_credit", 32'(imem_req_valid_o), 32'd1);
      check("st_pc_next0", pc_next_o, 32'h300);
      check("st_addr0", imem_addr_o, 32'h300);
      tick();
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_word(32'h204);
      #1;
      check("st_pc_next1", pc_next_o, 32'h300);
      check("st_addr1", imem_addr_o, 32'h300);
      tick();
      imem_rsp_valid_i = 1'b0;
      imem_req_ready_i = 1'b1;
      #1;
      check("rr_drop_iv", 32'(inst_valid_o), 32'd0);
      check("rr_issue_next", pc_next_o, 32'h304);
      tick();
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_word(32'h300);
      imem_req_ready_i = 1'b0;
      #1;
      check("st_pc_next2", pc_next_o, 32'h304);
      tick();
      imem_rsp_valid_i = 1'b0;
      #1;
      check("rr_kept_iv", 32'(inst_valid_o), 32'd1);
      check("rr_kept_pc", inst_pc_o, 32'h300);
      check("rr_kept_inst", inst_o, mem_word(32'h300));
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
